// File: rtl/cs_measure.sv
// cs_measure: compressive-sensing measurement engine.
//
// Takes a frame of N unsigned samples and produces M signed measurements
// y[m] = sum_n phi(m,n) * x[n], with phi a +/-1 Bernoulli matrix generated
// on the fly by a 16-bit Fibonacci LFSR.
//
// Handshakes use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high. Ready never depends on valid.
// Once out_valid is raised, out_data/out_last hold until out_ready is seen.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    sample stream in (DW-bit unsigned)
//   in_ready            high in COLLECT only
//   out_valid/out_data  measurement stream out (AW-bit signed)
//   out_last            marks y[M-1]
//   out_ready           downstream accept
//   frame_done          one-cycle pulse after the final output transfer
module cs_measure #(
  parameter int          N    = 64,
  parameter int          M    = 16,
  parameter int          DW   = 8,
  parameter int          AW   = 15,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          frame_done
);

  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    COLLECT = 2'd1,
    ACCUM   = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic          initWait;
  logic [15:0]   lfsr;
  logic [15:0]   lfsrNext;
  logic [DW-1:0] sample;
  logic [AW-1:0] sampleExt;
  logic [MW-1:0] mIdx;
  logic [MW-1:0] kIdx;
  logic [NW-1:0] sCnt;
  logic [AW-1:0] acc [M];
  logic          lastM;
  logic          lastK;
  logic          lastS;
  logic          outFire;

  assign lastM     = (mIdx == MW'(M - 1));
  assign lastK     = (kIdx == MW'(M - 1));
  assign lastS     = (sCnt == NW'(N - 1));
  assign sampleExt = {{(AW - DW){1'b0}}, sample};

  // Taps x^16+x^14+x^13+x^11+1, shifting right: new MSB = b0^b2^b3^b5.
  assign lfsrNext = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == OUTPUT);
  assign out_last  = out_valid && lastK;
  // Gated by state so the output reads zero the instant reset asserts.
  assign out_data  = out_valid ? acc[kIdx] : '0;
  assign outFire   = out_valid && out_ready;

  always_comb begin
    stateNext = state;
    case (state)
      // INIT spends two cycles (clear, then settle), so in_ready rises on
      // the second edge after reset release.
      INIT:    if (initWait) stateNext = COLLECT;
      COLLECT: if (in_valid) stateNext = ACCUM;
      ACCUM:   if (lastM) stateNext = lastS ? OUTPUT : COLLECT;
      OUTPUT:  if (out_ready && lastK) stateNext = COLLECT;
      default: stateNext = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      initWait   <= 1'b0;
      lfsr       <= SEED;
      sample     <= '0;
      mIdx       <= '0;
      kIdx       <= '0;
      sCnt       <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < M; i++) acc[i] <= '0;
    end else begin
      state      <= stateNext;
      initWait   <= (state == INIT);
      frame_done <= outFire && lastK;
      case (state)
        INIT: begin
          lfsr <= SEED;
          mIdx <= '0;
          kIdx <= '0;
          sCnt <= '0;
          for (int i = 0; i < M; i++) acc[i] <= '0;
        end
        COLLECT: begin
          if (in_valid) begin
            sample <= in_data;
            mIdx   <= '0;
          end
        end
        ACCUM: begin
          acc[mIdx] <= lfsr[0] ? (acc[mIdx] + sampleExt)
                               : (acc[mIdx] - sampleExt);
          lfsr      <= lfsrNext;
          mIdx      <= mIdx + 1'b1;
          if (lastM) begin
            if (lastS) kIdx <= '0;
            else       sCnt <= sCnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            kIdx <= kIdx + 1'b1;
            // Frame complete: reseed so every frame sees the same matrix.
            if (lastK) begin
              lfsr <= SEED;
              sCnt <= '0;
              kIdx <= '0;
              for (int i = 0; i < M; i++) acc[i] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_measure.sv
module tb_cs_measure;

  localparam int          N    = 64;
  localparam int          M    = 16;
  localparam int          DW   = 8;
  localparam int          AW   = 15;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          BP_K = 5;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          frame_done;

  always #5 clk = ~clk;

  cs_measure #(.N(N), .M(M), .DW(DW), .AW(AW), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_done(frame_done)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW:0]   exp_q[$];          // {last, data}
  logic [DW-1:0] frame_x [N];
  int            exp_frames = 0;
  int            done_cnt   = 0;
  bit            mon_en     = 1'b0;
  bit            rnd_ready  = 1'b0;
  int            bp_left    = 0;

  // Golden model: independent integer accumulation, truncated to AW bits.
  task automatic push_expected();
    logic [15:0] l;
    int          a [M];
    logic [AW-1:0] y;
    l = SEED;
    for (int m = 0; m < M; m++) a[m] = 0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        if (l[0]) a[m] = a[m] + int'(frame_x[n]);
        else      a[m] = a[m] - int'(frame_x[n]);
        l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      end
    end
    for (int m = 0; m < M; m++) begin
      y = AW'(a[m]);
      exp_q.push_back({(m == M - 1), y});
    end
    exp_frames++;
  endtask

  // Output monitor: decides out_ready and compares on each handshake.
  initial begin : monitor
    int  out_idx;
    bit  prev_last;
    bit  hs;
    logic [AW:0] e;
    out_idx   = 0;
    prev_last = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        out_ready = 1'b0;
        prev_last = 1'b0;
      end else begin
        if (prev_last || frame_done) begin
          check("frame_done_pulse", 32'(frame_done), 32'(prev_last));
          if (frame_done) begin
            done_cnt++;
            check("frame_done_in_ready", 32'(in_ready), 32'd1);
          end
        end
        if (out_valid && out_idx == BP_K && bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
          if (exp_q.size() > 0)
            check("stall_stable", 32'({out_last, out_data}), 32'(exp_q[0]));
        end else begin
          out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        hs = out_valid && out_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h expected=none", out_data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("y[%0d]", out_idx), 32'({out_last, out_data}), 32'(e));
          end
          out_idx = out_last ? 0 : out_idx + 1;
        end
        prev_last = hs && out_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_samples(input int count, input bit toggle);
    int wait_cnt;
    bit sent;
    for (int i = 0; i < count; i++) begin
      wait_cnt = 0;
      sent     = 1'b0;
      while (!sent) begin
        @(negedge clk);
        if (in_ready) begin
          in_valid = 1'b1;
          in_data  = frame_x[i];
          @(posedge clk);
          sent = 1'b1;
        end else begin
          // Traffic while not ready must never be counted as a sample.
          in_valid = toggle ? ~in_valid : 1'b0;
          in_data  = DW'($urandom);
          wait_cnt++;
          if (wait_cnt > 1000) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 expected=1 sample=%0d", i);
            return;
          end
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill_frame(input int kind);
    for (int n = 0; n < N; n++) begin
      case (kind)
        0:       frame_x[n] = '0;
        1:       frame_x[n] = (n == 0) ? DW'(255) : '0;
        2:       frame_x[n] = DW'(255);
        3:       frame_x[n] = DW'($urandom_range(0, 255));
        default: ;  // keep previous frame's data
      endcase
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || done_cnt != exp_frames) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_done_count", 32'(done_cnt), 32'(exp_frames));
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_out_data"},   32'(out_data),   32'd0);
    check({tag, "_out_last"},   32'(out_last),   32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({tag, "_in_ready_edge1"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_in_ready_edge2"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int kind;        // 0 zero, 1 impulse, 2 full scale, 3 random, 4 repeat
    bit toggle;      // toggle in_valid while not ready
    bit rnd_ready;   // random out_ready stalls
    int bp;          // cycles of out_ready low at k=BP_K
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    int guard;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #3;
    check_outs_zero("reset");
    release_reset("por");

    vecs[0] = '{kind: 0, toggle: 1'b0, rnd_ready: 1'b0, bp: 0};
    vecs[1] = '{kind: 1, toggle: 1'b0, rnd_ready: 1'b0, bp: 0};
    vecs[2] = '{kind: 2, toggle: 1'b0, rnd_ready: 1'b0, bp: 0};
    vecs[3] = '{kind: 4, toggle: 1'b1, rnd_ready: 1'b0, bp: 10};
    for (int v = 4; v < NV - 1; v++)
      vecs[v] = '{kind: 3, toggle: v[0], rnd_ready: ~v[0], bp: 0};
    vecs[NV - 1] = '{kind: 4, toggle: 1'b0, rnd_ready: 1'b0, bp: 0};

    mon_en = 1'b1;
    for (int v = 0; v < NV; v++) begin
      fill_frame(vecs[v].kind);
      send_samples(N, vecs[v].toggle);
      push_expected();
      rnd_ready = vecs[v].rnd_ready;
      bp_left   = vecs[v].bp;
    end
    drain();
    rnd_ready = 1'b0;

    // Reset mid-ACCUM after 30 samples, then a fresh frame.
    fill_frame(3);
    send_samples(30, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("accum_reset");
    release_reset("accum_rel");
    fill_frame(3);
    send_samples(N, 1'b0);
    push_expected();
    drain();

    // Reset while a frame is being output: no output may follow for it.
    mon_en = 1'b0;
    fill_frame(2);
    send_samples(N, 1'b0);
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("output_reached", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outs_zero("output_reset");
    release_reset("output_rel");
    mon_en = 1'b1;
    fill_frame(3);
    send_samples(N, 1'b1);
    push_expected();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
